id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus operand-select/forwarding front end for the ALU. Captures decoded

---
 rtl/id_ex_operand_stage_pkg.sv | 61 ++++++
 rtl/id_ex_operand_stage_if.sv | 48 ++++
 rtl/id_ex_operand_stage_hazard_forward_unit.sv | 57 +++++
 rtl/id_ex_operand_stage.sv | 116 +++++++++++
 tb/tb_id_ex_operand_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage_pkg
// Shared definitions for the ID/EX operand stage:
//   - width constants for operands, ALU op and register indices
//   - ALU operation encoding (shared with the execute-stage ALU)
//   - result-source encoding and forward-select encoding
//   - id_ex_t: every field held in the ID/EX pipeline register
//   - ID_EX_BUBBLE: the all-zero register image used for reset and bubbles
// -----------------------------------------------------------------------------
package id_ex_operand_stage_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int REG_W  = 5;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [OP_W-1:0]   alu_control;
        logic              alu_src_a;
        logic              alu_src_b;
        logic              reg_write;
        logic              mem_write;
        logic [1:0]        result_src;
    } id_ex_t;

    // All-zero image: ValidE=0, no writes, ADD, ALU result source.
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage_if
// Bundles every non-clock signal of the ID/EX operand stage.
//   master : decode fields, EX/MEM + MEM/WB feedback, stall/flush in;
//            StallD and all execute-stage outputs back.
//   slave  : the operand stage itself (mirror of master).
// -----------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int REG_ADDR_W = 5
);
    // decode side
    logic                  ValidD;
    logic [DATA_WIDTH-1:0] RD1D, RD2D, ImmExtD, PCD;
    logic [REG_ADDR_W-1:0] Rs1D, Rs2D, RdD;
    logic [OP_WIDTH-1:0]   ALUControlD;
    logic                  ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD;
    logic [1:0]            ResultSrcD;
    // later-stage feedback
    logic [DATA_WIDTH-1:0] ALUResultM, ResultW;
    logic [REG_ADDR_W-1:0] RdM, RdW;
    logic                  RegWriteM, RegWriteW;
    logic                  StallE, FlushE;
    // outputs
    logic                  StallD;
    logic [DATA_WIDTH-1:0] SrcA, SrcB, WriteDataE, PCE, ImmExtE;
    logic [OP_WIDTH-1:0]   ALUControlE;
    logic [REG_ADDR_W-1:0] RdE;
    logic                  RegWriteE, MemWriteE, ValidE;
    logic [1:0]            ResultSrcE;

    modport master (
        output ValidD, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD, ALUControlD,
               ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD, ResultSrcD,
               ALUResultM, ResultW, RdM, RdW, RegWriteM, RegWriteW, StallE, FlushE,
        input  StallD, SrcA, SrcB, WriteDataE, PCE, ImmExtE, ALUControlE, RdE,
               RegWriteE, MemWriteE, ValidE, ResultSrcE
    );

    modport slave (
        input  ValidD, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD, ALUControlD,
               ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD, ResultSrcD,
               ALUResultM, ResultW, RdM, RdW, RegWriteM, RegWriteW, StallE, FlushE,
        output StallD, SrcA, SrcB, WriteDataE, PCE, ImmExtE, ALUControlE, RdE,
               RegWriteE, MemWriteE, ValidE, ResultSrcE
    );
endinterface

// File: rtl/id_ex_operand_stage_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
// Purely combinational.
//   load_use   : the instruction in E is a valid load whose rd (non-zero) is
//                read by the valid instruction in D.
//   fwd_a_sel  : operand source for rs1 of the E instruction (REG/MEM/WB)
//   fwd_b_sel  : operand source for rs2 of the E instruction (REG/MEM/WB)
// x0 is never forwarded; EX/MEM wins over MEM/WB because it is younger.
// -----------------------------------------------------------------------------
module hazard_forward_unit
    import id_ex_operand_stage_pkg::*;
#(
    parameter int REG_ADDR_W = REG_W
) (
    input  logic                  valid_e,
    input  logic [1:0]            result_src_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic                  valid_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    output logic                  load_use,
    output fwd_sel_t              fwd_a_sel,
    output fwd_sel_t              fwd_b_sel
);

    always_comb begin
        load_use = valid_e && (result_src_e == RES_LOAD) && (rd_e != '0) && valid_d &&
                   ((rs1_d == rd_e) || (rs2_d == rd_e));
    end

    // One identical selector per source operand: index 0 = rs1, 1 = rs2.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [REG_ADDR_W-1:0] rs;
        fwd_sel_t              sel;

        assign rs = (gi == 0) ? rs1_e : rs2_e;

        always_comb begin
            sel = FWD_REG;
            if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
                sel = FWD_MEM;
            end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
                sel = FWD_WB;
            end
        end
    end

    assign fwd_a_sel = g_fwd[0].sel;
    assign fwd_b_sel = g_fwd[1].sel;

endmodule

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
// ID/EX pipeline register plus operand select / forwarding for the ALU.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of id_ex_operand_stage_if
//              in : decode fields (…D), EX/MEM and MEM/WB feedback, StallE, FlushE
//              out: StallD, SrcA, SrcB, WriteDataE and the registered E fields
// Register update priority: rst > StallE (hold) > FlushE > load-use > load D.
// Field widths of the register come from the package constants; the
// parameters must be left at their defaults unless the package changes too.
// -----------------------------------------------------------------------------
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int OP_WIDTH   = OP_W,
    parameter int REG_ADDR_W = REG_W
) (
    input logic                  clk,
    input logic                  rst,
    id_ex_operand_stage_if.slave bus
);

    id_ex_t                id_ex_q;
    id_ex_t                id_ex_d;
    logic                  load_use;
    fwd_sel_t              fwd_a_sel;
    fwd_sel_t              fwd_b_sel;
    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;
    logic [OP_WIDTH-1:0]   alu_control_e;

    hazard_forward_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_forward_unit (
        .valid_e      (id_ex_q.valid),
        .result_src_e (id_ex_q.result_src),
        .rd_e         (id_ex_q.rd),
        .rs1_e        (id_ex_q.rs1),
        .rs2_e        (id_ex_q.rs2),
        .valid_d      (bus.ValidD),
        .rs1_d        (bus.Rs1D),
        .rs2_d        (bus.Rs2D),
        .rd_m         (bus.RdM),
        .reg_write_m  (bus.RegWriteM),
        .rd_w         (bus.RdW),
        .reg_write_w  (bus.RegWriteW),
        .load_use     (load_use),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel)
    );

    // Next-state of the ID/EX register.
    always_comb begin
        id_ex_d = id_ex_q;
        if (bus.StallE) begin
            id_ex_d = id_ex_q;
        end else if (bus.FlushE || load_use) begin
            id_ex_d = ID_EX_BUBBLE;
        end else begin
            id_ex_d.valid       = bus.ValidD;
            id_ex_d.rs1         = bus.Rs1D;
            id_ex_d.rs2         = bus.Rs2D;
            id_ex_d.rd          = bus.RdD;
            id_ex_d.rd1         = bus.RD1D;
            id_ex_d.rd2         = bus.RD2D;
            id_ex_d.imm         = bus.ImmExtD;
            id_ex_d.pc          = bus.PCD;
            id_ex_d.alu_control = bus.ALUControlD;
            id_ex_d.alu_src_a   = bus.ALUSrcAD;
            id_ex_d.alu_src_b   = bus.ALUSrcBD;
            // An empty decode slot must never commit anything downstream.
            id_ex_d.reg_write   = bus.RegWriteD && bus.ValidD;
            id_ex_d.mem_write   = bus.MemWriteD && bus.ValidD;
            id_ex_d.result_src  = bus.ResultSrcD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q <= ID_EX_BUBBLE;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    // Forwarding muxes operate on the registered E indices, so they are zero-cycle.
    always_comb begin
        case (fwd_a_sel)
            FWD_MEM: fwd_a = bus.ALUResultM;
            FWD_WB:  fwd_a = bus.ResultW;
            default: fwd_a = id_ex_q.rd1;
        endcase
        case (fwd_b_sel)
            FWD_MEM: fwd_b = bus.ALUResultM;
            FWD_WB:  fwd_b = bus.ResultW;
            default: fwd_b = id_ex_q.rd2;
        endcase
    end

    assign alu_control_e   = id_ex_q.alu_control;

    assign bus.StallD      = load_use || bus.StallE;
    assign bus.SrcA        = id_ex_q.alu_src_a ? id_ex_q.pc  : fwd_a;
    assign bus.SrcB        = id_ex_q.alu_src_b ? id_ex_q.imm : fwd_b;
    assign bus.WriteDataE  = fwd_b;
    assign bus.ALUControlE = alu_control_e;
    assign bus.PCE         = id_ex_q.pc;
    assign bus.ImmExtE     = id_ex_q.imm;
    assign bus.RdE         = id_ex_q.rd;
    assign bus.RegWriteE   = id_ex_q.reg_write;
    assign bus.MemWriteE   = id_ex_q.mem_write;
    assign bus.ValidE      = id_ex_q.valid;
    assign bus.ResultSrcE  = id_ex_q.result_src;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_stage
// Directed scenarios followed by a randomized run. A reference model keeps the
// instruction currently "in execute" as a plain record and derives expected
// outputs from the pipeline rules (hold / kill / load-use bubble / capture,
// then youngest-producer forwarding).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_ex_operand_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction sitting in execute, as the model sees it.
    typedef struct {
        bit          valid;
        bit [4:0]    rs1, rs2, rd;
        bit [31:0]   rd1, rd2, imm, pc;
        bit [3:0]    op;
        bit          use_pc, use_imm, regw, memw;
        bit [1:0]    rsrc;
    } instr_t;

    instr_t ex_m;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic instr_t empty_slot();
        instr_t e;
        e = '{default: 0};
        return e;
    endfunction

    // Does the current decode instruction need a result the load in E has not produced yet?
    function automatic bit model_load_use();
        return ex_m.valid && ex_m.rsrc == 2'b01 && ex_m.rd != 0 && bus.ValidD &&
               (bus.Rs1D == ex_m.rd || bus.Rs2D == ex_m.rd);
    endfunction

    // Value the E instruction should see for source register rs.
    function automatic bit [31:0] operand(input bit [4:0] rs, input bit [31:0] file_val);
        if (rs == 0) return file_val;
        if (bus.RegWriteM && bus.RdM == rs) return bus.ALUResultM;
        if (bus.RegWriteW && bus.RdW == rs) return bus.ResultW;
        return file_val;
    endfunction

    task automatic check_all(input string ctx);
        bit [31:0] a, b;
        a = operand(ex_m.rs1, ex_m.rd1);
        b = operand(ex_m.rs2, ex_m.rd2);
        chk({ctx, ".SrcA"},        bus.SrcA,        ex_m.use_pc  ? ex_m.pc  : a);
        chk({ctx, ".SrcB"},        bus.SrcB,        ex_m.use_imm ? ex_m.imm : b);
        chk({ctx, ".WriteDataE"},  bus.WriteDataE,  b);
        chk({ctx, ".ALUControlE"}, 32'(bus.ALUControlE), 32'(ex_m.op));
        chk({ctx, ".PCE"},         bus.PCE,         ex_m.pc);
        chk({ctx, ".ImmExtE"},     bus.ImmExtE,     ex_m.imm);
        chk({ctx, ".RdE"},         32'(bus.RdE),    32'(ex_m.rd));
        chk({ctx, ".RegWriteE"},   32'(bus.RegWriteE), 32'(ex_m.regw));
        chk({ctx, ".MemWriteE"},   32'(bus.MemWriteE), 32'(ex_m.memw));
        chk({ctx, ".ValidE"},      32'(bus.ValidE), 32'(ex_m.valid));
        chk({ctx, ".ResultSrcE"},  32'(bus.ResultSrcE), 32'(ex_m.rsrc));
        chk({ctx, ".StallD"},      32'(bus.StallD), 32'(model_load_use() || bus.StallE));
    endtask

    // One clock edge: work out what execute should hold afterwards, then advance.
    task automatic step();
        instr_t nxt;
        if (rst || bus.FlushE && !bus.StallE || model_load_use() && !bus.StallE) begin
            nxt = empty_slot();
        end else if (bus.StallE) begin
            nxt = ex_m;
        end else begin
            nxt.valid   = bus.ValidD;
            nxt.rs1     = bus.Rs1D;       nxt.rs2 = bus.Rs2D;   nxt.rd  = bus.RdD;
            nxt.rd1     = bus.RD1D;       nxt.rd2 = bus.RD2D;
            nxt.imm     = bus.ImmExtD;    nxt.pc  = bus.PCD;    nxt.op  = bus.ALUControlD;
            nxt.use_pc  = bus.ALUSrcAD;   nxt.use_imm = bus.ALUSrcBD;
            nxt.regw    = bus.RegWriteD && bus.ValidD;
            nxt.memw    = bus.MemWriteD && bus.ValidD;
            nxt.rsrc    = bus.ResultSrcD;
        end
        @(posedge clk);
        ex_m = nxt;
        #1;
    endtask

    task automatic random_d();
        bus.ValidD      = ($urandom_range(0, 7) != 0);
        bus.RD1D        = $urandom;
        bus.RD2D        = $urandom;
        bus.ImmExtD     = $urandom;
        bus.PCD         = $urandom;
        bus.Rs1D        = 5'($urandom_range(0, 7));
        bus.Rs2D        = 5'($urandom_range(0, 7));
        bus.RdD         = 5'($urandom_range(0, 7));
        bus.ALUControlD = 4'($urandom_range(0, 9));
        bus.ALUSrcAD    = 1'($urandom);
        bus.ALUSrcBD    = 1'($urandom);
        bus.RegWriteD   = 1'($urandom);
        bus.MemWriteD   = 1'($urandom);
        bus.ResultSrcD  = 2'($urandom_range(0, 2));
    endtask

    task automatic random_mw();
        bus.ALUResultM = $urandom;
        bus.ResultW    = $urandom;
        bus.RdM        = 5'($urandom_range(0, 7));
        bus.RdW        = 5'($urandom_range(0, 7));
        bus.RegWriteM  = 1'($urandom);
        bus.RegWriteW  = 1'($urandom);
    endtask

    // Plain valid ALU instruction in decode, no feedback activity.
    task automatic quiet_d();
        bus.ValidD = 1; bus.RD1D = 32'h1; bus.RD2D = 32'h2; bus.ImmExtD = 32'h100;
        bus.PCD = 32'h400; bus.Rs1D = 5'd1; bus.Rs2D = 5'd2; bus.RdD = 5'd9;
        bus.ALUControlD = 4'b0000; bus.ALUSrcAD = 0; bus.ALUSrcBD = 0;
        bus.RegWriteD = 1; bus.MemWriteD = 0; bus.ResultSrcD = 2'b00;
        bus.ALUResultM = 0; bus.ResultW = 0; bus.RdM = 0; bus.RdW = 0;
        bus.RegWriteM = 0; bus.RegWriteW = 0;
        bus.StallE = 0; bus.FlushE = 0;
    endtask

    initial begin
        bit [31:0] held_pc, held_imm;
        ex_m = empty_slot();

        // 1: reset with garbage on the decode side
        rst = 1;
        random_d();
        random_mw();
        bus.StallE = 0; bus.FlushE = 0;
        step();
        step();
        chk("rst.ValidE",      32'(bus.ValidE), 32'd0);
        chk("rst.RegWriteE",   32'(bus.RegWriteE), 32'd0);
        chk("rst.ALUControlE", 32'(bus.ALUControlE), 32'd0);
        chk("rst.StallD",      32'(bus.StallD), 32'(bus.StallE));
        check_all("rst");
        rst = 0;

        // 2: rs1 forwarded from MEM, then from the register file
        quiet_d();
        bus.Rs1D = 5'd5; bus.RD1D = 32'h1;
        step();
        bus.RdM = 5'd5; bus.RegWriteM = 1; bus.ALUResultM = 32'h10;
        #1;
        chk("fwdM.SrcA", bus.SrcA, 32'h10);
        bus.RegWriteM = 0;
        #1;
        chk("noFwd.SrcA", bus.SrcA, 32'h1);
        check_all("s2");

        // 3: MEM beats WB for the same register
        quiet_d();
        bus.Rs2D = 5'd7;
        step();
        bus.RdM = 5'd7; bus.RdW = 5'd7; bus.RegWriteM = 1; bus.RegWriteW = 1;
        bus.ALUResultM = 32'hAA; bus.ResultW = 32'hBB;
        #1;
        chk("prio.SrcB",       bus.SrcB, 32'hAA);
        chk("prio.WriteDataE", bus.WriteDataE, 32'hAA);
        bus.RegWriteM = 0;
        #1;
        chk("fwdW.SrcB",       bus.SrcB, 32'hBB);

        // 4: x0 is never forwarded
        quiet_d();
        bus.Rs1D = 5'd0; bus.RD1D = 32'h55;
        step();
        bus.RdM = 5'd0; bus.RegWriteM = 1; bus.ALUResultM = 32'hFF;
        #1;
        chk("x0.SrcA", bus.SrcA, 32'h55);

        // 5: lw x3 then add x4,x3,x1
        quiet_d();
        bus.RdD = 5'd3; bus.ResultSrcD = 2'b01;
        step();
        bus.Rs1D = 5'd3; bus.Rs2D = 5'd1; bus.RdD = 5'd4; bus.ResultSrcD = 2'b00;
        #1;
        chk("lu.StallD", 32'(bus.StallD), 32'd1);
        step();
        chk("lu.ValidE",    32'(bus.ValidE), 32'd0);
        chk("lu.RegWriteE", 32'(bus.RegWriteE), 32'd0);
        step();
        chk("lu.RdE",       32'(bus.RdE), 32'd4);
        bus.RdM = 5'd3; bus.RegWriteM = 1; bus.ALUResultM = 32'h1234;
        #1;
        chk("lu.SrcA",      bus.SrcA, 32'h1234);
        check_all("s5");

        // 6: hold for three cycles, then flush
        quiet_d();
        bus.MemWriteD = 1; bus.PCD = 32'h800; bus.ImmExtD = 32'h44;
        step();
        held_pc = 32'h800; held_imm = 32'h44;
        bus.StallE = 1;
        for (int i = 0; i < 3; i++) begin
            random_d();
            step();
            chk("hold.PCE",       bus.PCE, held_pc);
            chk("hold.ImmExtE",   bus.ImmExtE, held_imm);
            chk("hold.MemWriteE", 32'(bus.MemWriteE), 32'd1);
            chk("hold.StallD",    32'(bus.StallD), 32'd1);
        end
        bus.StallE = 0; bus.FlushE = 1;
        step();
        chk("flush.ValidE",    32'(bus.ValidE), 32'd0);
        chk("flush.MemWriteE", 32'(bus.MemWriteE), 32'd0);
        bus.FlushE = 0;

        // Randomized run against the model
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            bus.StallE = ($urandom_range(0, 7) == 0);
            bus.FlushE = ($urandom_range(0, 7) == 0);
            random_d();
            random_mw();
            #1;
            check_all("pre");
            step();
            check_all("post");
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
